// File: rtl/expr_stim_pkg.sv
// Purpose: shared widths, LFSR/MISR constants, FSM state type and helpers for the expression stimulus/response engine.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package expr_stim_pkg;

  // Operand bus: {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5} = 2 x (4+5+6+4+5+6) bits.
  localparam int OPND_W = 60;
  // Response bus: {y0..y17}, packed.
  localparam int RESP_W = 90;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 16;

  // Galois LFSR x^64+x^63+x^61+x^60+1, right-shifting form.
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  // CRC-32 polynomial used for the MISR.
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 64'd0);
  endfunction

  // Compress the 90-bit response into one 32-bit word for the MISR.
  function automatic logic [SIG_W-1:0] misr_fold(input logic [RESP_W-1:0] d);
    return d[31:0] ^ d[63:32] ^ {6'b0, d[89:64]};
  endfunction

endpackage

// File: rtl/expr_misr.sv
// Purpose: 32-bit multiple-input signature register folding a 90-bit response per enabled cycle.
// Latency: signature reflects a capture one clock after en is sampled.
// Backpressure: none; init has priority over en, otherwise the signature holds.
module expr_misr
  import expr_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next signature: reload on init, shift/poly/fold on en, hold otherwise.
  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = MISR_INIT;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
            ^ misr_fold(data);
    end
  end

  // Signature register, cleared to zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/expr_stim_resp.sv
// Purpose: LFSR-driven operand generator plus MISR response compactor for an expression DUT; optional abort input under EXPR_STIM_ABORT_EN.
// Latency: NUM_VECTORS*(2+LATENCY) clocks from start sample to DONE.
// Backpressure: none; start is ignored while busy, abort (when built in) ends a run at the next edge.
module expr_stim_resp
  import expr_stim_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001,
  parameter int          LATENCY     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef EXPR_STIM_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [3:0]        a0,
  output logic [4:0]        a1,
  output logic [5:0]        a2,
  output logic signed [3:0] a3,
  output logic signed [4:0] a4,
  output logic signed [5:0] a5,
  output logic [3:0]        b0,
  output logic [4:0]        b1,
  output logic [5:0]        b2,
  output logic signed [3:0] b3,
  output logic signed [4:0] b4,
  output logic signed [5:0] b5,
  input  logic [RESP_W-1:0] y,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);

  // Last WAIT count value; unused when LATENCY is zero since WAIT is skipped.
  localparam logic [3:0]       WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [CNT_W-1:0] NV        = CNT_W'(NUM_VECTORS);
  localparam bit               HAS_WAIT  = (LATENCY > 0);

  state_e            state_q, state_d;
  logic [63:0]       lfsr_q, lfsr_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        wait_q, wait_d;
  logic              misr_init;
  logic              misr_en;
  logic              busy_w;

  assign busy_w = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);

  // Run sequencer: start -> (DRIVE [WAIT*] CAPTURE) x NUM_VECTORS -> DONE.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    misr_init = 1'b0;
    misr_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_d    = SEED;
          cnt_d     = '0;
          misr_init = 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Operands are only ever written here, so they stay put until the next DRIVE.
        opnd_d  = lfsr_q[OPND_W-1:0];
        lfsr_d  = lfsr_step(lfsr_q);
        wait_d  = '0;
        state_d = HAS_WAIT ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Compare the post-increment count so the run stops without wrapping.
        state_d = (cnt_d == NV) ? ST_DONE : ST_DRIVE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef EXPR_STIM_ABORT_EN
    // Abort wins over everything in flight, including a coincident capture.
    if (busy_w && abort) begin
      state_d = ST_DONE;
      lfsr_d  = lfsr_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      misr_en = 1'b0;
    end
`endif
  end

  // Sequencer, LFSR, operand, counter and wait registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      opnd_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  expr_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (misr_init),
    .en    (misr_en),
    .data  (y),
    .sig   (signature)
  );

  assign {a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5} = opnd_q;
  assign busy      = busy_w;
  assign done      = (state_q == ST_DONE);
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_expr_stim_resp.sv
// Purpose: directed self-checking bench for expr_stim_resp (short single-vector run, latency run, restarts, reset, abort).
// Latency: expectations are fixed-cycle schedules counted from the start edge.
// Backpressure: n/a.
module tb_expr_stim_resp;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: NUM_VECTORS=1, LATENCY=0, y=0 ----------------
  logic        start_a, busy_a, done_a;
  logic [3:0]  a_a0, a_a3, a_b0, a_b3;
  logic [4:0]  a_a1, a_a4, a_b1, a_b4;
  logic [5:0]  a_a2, a_a5, a_b2, a_b5;
  logic [89:0] y_a;
  logic [31:0] sig_a;
  logic [15:0] cnt_a;
  logic [59:0] opnd_a;
  assign y_a    = '0;
  assign opnd_a = {a_a0, a_a1, a_a2, a_a3, a_a4, a_a5, a_b0, a_b1, a_b2, a_b3, a_b4, a_b5};

  // ---------------- instance B: NUM_VECTORS=4, LATENCY=2, y = operands ----------------
  logic        start_b, busy_b, done_b;
  logic [3:0]  b_a0, b_a3, b_b0, b_b3;
  logic [4:0]  b_a1, b_a4, b_b1, b_b4;
  logic [5:0]  b_a2, b_a5, b_b2, b_b5;
  logic [89:0] y_b;
  logic [31:0] sig_b;
  logic [15:0] cnt_b;
  logic [59:0] opnd_b;
  assign opnd_b = {b_a0, b_a1, b_a2, b_a3, b_a4, b_a5, b_b0, b_b1, b_b2, b_b3, b_b4, b_b5};
  assign y_b    = {30'b0, opnd_b};

`ifdef EXPR_STIM_ABORT_EN
  logic abort_a, abort_b;
  assign abort_a = 1'b0;
  assign abort_b = 1'b0;
`endif

  expr_stim_resp #(.NUM_VECTORS(1), .SEED(64'h1), .LATENCY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef EXPR_STIM_ABORT_EN
    .abort(abort_a),
`endif
    .busy(busy_a), .done(done_a),
    .a0(a_a0), .a1(a_a1), .a2(a_a2), .a3(a_a3), .a4(a_a4), .a5(a_a5),
    .b0(a_b0), .b1(a_b1), .b2(a_b2), .b3(a_b3), .b4(a_b4), .b5(a_b5),
    .y(y_a), .signature(sig_a), .vec_count(cnt_a)
  );

  expr_stim_resp #(.NUM_VECTORS(4), .SEED(64'h1), .LATENCY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef EXPR_STIM_ABORT_EN
    .abort(abort_b),
`endif
    .busy(busy_b), .done(done_b),
    .a0(b_a0), .a1(b_a1), .a2(b_a2), .a3(b_a3), .a4(b_a4), .a5(b_a5),
    .b0(b_b0), .b1(b_b1), .b2(b_b2), .b3(b_b3), .b4(b_b4), .b5(b_b5),
    .y(y_b), .signature(sig_b), .vec_count(cnt_b)
  );

`ifdef EXPR_STIM_ABORT_EN
  // ---------------- instance C: NUM_VECTORS=8, LATENCY=0, abort ----------------
  logic        start_c, abort_c, busy_c, done_c;
  logic [3:0]  c_a0, c_a3, c_b0, c_b3;
  logic [4:0]  c_a1, c_a4, c_b1, c_b4;
  logic [5:0]  c_a2, c_a5, c_b2, c_b5;
  logic [89:0] y_c;
  logic [31:0] sig_c;
  logic [15:0] cnt_c;
  assign y_c = {30'b0, c_a0, c_a1, c_a2, c_a3, c_a4, c_a5, c_b0, c_b1, c_b2, c_b3, c_b4, c_b5};

  expr_stim_resp #(.NUM_VECTORS(8), .SEED(64'h1), .LATENCY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
    .busy(busy_c), .done(done_c),
    .a0(c_a0), .a1(c_a1), .a2(c_a2), .a3(c_a3), .a4(c_a4), .a5(c_a5),
    .b0(c_b0), .b1(c_b1), .b2(c_b2), .b3(c_b3), .b4(c_b4), .b5(c_b5),
    .y(y_c), .signature(sig_c), .vec_count(cnt_c)
  );
`endif

  // Hand-computed per-vector expectations for a SEED=1 run with y = {30'b0, operands}.
  typedef struct {
    logic [59:0] opnd;
    logic [31:0] sig;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run of instance B; optional start pulses while busy must be ignored.
  task automatic run_b(input bit glitch);
    int busy_cycles;
    int done_edge;
    busy_cycles = 0;
    done_edge   = -1;
    start_b = 1'b1;
    tick();                               // edge 0
    start_b = 1'b0;
    check("b_done_drop", {63'b0, done_b}, 64'd0);
    if (busy_b) busy_cycles++;
    for (int e = 1; e <= 20; e++) begin
      if (glitch && (e == 3 || e == 8 || e == 13)) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      if (e <= 14 && ((e - 2) % 4) == 0)
        check($sformatf("b_opnd%0d", (e - 2) / 4), {4'b0, opnd_b}, {4'b0, tbl[(e - 2) / 4].opnd});
      if (e <= 16 && (e % 4) == 0) begin
        check($sformatf("b_sig%0d", e / 4 - 1), {32'b0, sig_b}, {32'b0, tbl[e / 4 - 1].sig});
        check($sformatf("b_cnt%0d", e / 4 - 1), {48'b0, cnt_b}, {48'b0, tbl[e / 4 - 1].cnt});
      end
      if (e <= 15 && busy_b) busy_cycles++;
      if (done_b && done_edge < 0) done_edge = e;
    end
    check("b_busy_cycles", 64'(busy_cycles), 64'd16);
    check("b_done_edge", 64'(done_edge), 64'd16);
    check("b_hold", {30'b0, busy_b, done_b, sig_b}, {30'b0, 1'b0, 1'b1, 32'hF9B0_4245});
    check("b_cnt_hold", {48'b0, cnt_b}, 64'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef EXPR_STIM_ABORT_EN
    start_c = 1'b0;
    abort_c = 1'b0;
`endif

    tbl[0] = '{opnd: 60'h000_0000_0000_0001, sig: 32'hFB3E_E248, cnt: 16'd1};
    tbl[1] = '{opnd: 60'h800_0000_0000_0000, sig: 32'hFABC_D927, cnt: 16'd2};
    tbl[2] = '{opnd: 60'hC00_0000_0000_0000, sig: 32'hFDB8_AFF9, cnt: 16'd3};
    tbl[3] = '{opnd: 60'h600_0000_0000_0000, sig: 32'hF9B0_4245, cnt: 16'd4};

    // Reset state.
    #12;
    check("rst_a", {busy_a, done_a, sig_a, cnt_a, opnd_a}, 110'd0);
    check("rst_b", {busy_b, done_b, sig_b, cnt_b, opnd_b}, 110'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single vector, zero latency, y=0.
    start_a = 1'b1;
    tick();                               // edge 0
    start_a = 1'b0;
    check("a_busy_e0", {62'b0, busy_a, done_a}, 64'b10);
    tick();                               // edge 1
    check("a_opnd_e1", {4'b0, opnd_a}, 64'd1);
    check("a_done_e1", {63'b0, done_a}, 64'd0);
    tick();                               // edge 2
    check("a_done_e2", {62'b0, busy_a, done_a}, 64'b01);
    check("a_sig", {32'b0, sig_a}, 64'hFB3E_E249);
    check("a_cnt", {48'b0, cnt_a}, 64'd1);
    tick();
    tick();
    check("a_hold", {15'b0, done_a, sig_a, cnt_a}, {15'b0, 1'b1, 32'hFB3E_E249, 16'd1});

    // Latency run, then a disturbed run started from DONE (back to back).
    run_b(1'b0);
    run_b(1'b1);

    // Reset mid-WAIT, then a clean rerun.
    start_b = 1'b1;
    tick();                               // edge 0
    start_b = 1'b0;
    tick();                               // edge 1: DRIVE
    tick();                               // edge 2: WAIT
    check("b_busy_wait", {63'b0, busy_b}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("b_rst_mid", {busy_b, done_b, sig_b, cnt_b, opnd_b}, 110'd0);
    tick();
    check("b_rst_held", {busy_b, done_b, sig_b, cnt_b, opnd_b}, 110'd0);
    rst_n = 1'b1;
    tick();
    run_b(1'b0);

`ifdef EXPR_STIM_ABORT_EN
    // Abort coincident with the third CAPTURE (edges: D1 C2 D3 C4 D5 C6).
    start_c = 1'b1;
    tick();                               // edge 0
    start_c = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    abort_c = 1'b1;
    tick();                               // edge 6
    abort_c = 1'b0;
    check("c_abort_done", {62'b0, busy_c, done_c}, 64'b01);
    check("c_abort_cnt", {48'b0, cnt_c}, 64'd2);
    check("c_abort_sig", {32'b0, sig_c}, 64'hFABC_D927);
    tick();
    tick();
    check("c_abort_hold", {15'b0, done_c, sig_c, cnt_c}, {15'b0, 1'b1, 32'hFABC_D927, 16'd2});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
